arm_bus_master: RTL and testbench

Bus initiator that drives the ARM-style chip-select/strobe interface (address, data, as, rs_n, ws_n, be) used by the FPGA register-file slaves. It takes single read or write commands on a valid/ready port, sequences the bus strobes with fixed, parameterised timing, captures read data after a fixed latency, and returns one response per command. It sits in the FPGA fabric between internal command sources (test sequencers, DMA stubs) and the slave register files.

---
 rtl/arm_bus_pkg.sv | 41 ++++
 rtl/arm_bus_master_if.sv | 36 +++
 rtl/arm_bus_be_cmp.sv | 14 +
 rtl/arm_bus_master.sv | 210 +++++++++++++++++++++
 tb/tb_arm_bus_master.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_bus_pkg.sv
// arm_bus_pkg: shared definitions for the ARM-style chip-select/strobe bus master.
//   - state_e        : master FSM states (V* states exist only with ARM_BUS_MASTER_VERIFY_EN)
//   - ADDR_W/DATA_W/BE_W : bus widths
//   - STROBE_IDLE_N / AS_IDLE : idle levels of the strobes and chip select
//   - SLAVE_RESET_VAL : reset value of the slave register files (for benches)
//   - be_to_mask()   : expands byte enables into a 32-bit bit mask
package arm_bus_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic STROBE_IDLE_N = 1'b1;
    localparam logic AS_IDLE       = 1'b0;

    localparam logic [DATA_W-1:0] SLAVE_RESET_VAL = 32'hfee1_dead;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
`ifdef ARM_BUS_MASTER_VERIFY_EN
        ,
        ST_VSETUP  = 3'd5,
        ST_VSTROBE = 3'd6,
        ST_VWAIT   = 3'd7
`endif
    } state_e;

    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = {DATA_W{1'b0}};
        for (int i = 0; i < BE_W; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/arm_bus_master_if.sv
// arm_bus_master_if: command, response and slave-bus signals of arm_bus_master.
//   modport master : the bus master's view (commands in, responses and bus strobes out)
//   modport slave  : the environment's view (command source, response sink, slave side)
interface arm_bus_master_if;
    import arm_bus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic [BE_W-1:0]   bus_be;
    logic              bus_as;
    logic              bus_rs_n;
    logic              bus_ws_n;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready, bus_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_address, bus_wdata, bus_be, bus_as, bus_rs_n, bus_ws_n
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_address, bus_wdata, bus_be, bus_as, bus_rs_n, bus_ws_n
    );
endinterface

// File: rtl/arm_bus_be_cmp.sv
// arm_bus_be_cmp: byte-masked 32-bit compare used by write verification.
//   a, b     : words to compare
//   be       : byte enables; only enabled bytes take part (be = 0 never mismatches)
//   mismatch : 1 when any enabled byte differs
module arm_bus_be_cmp
    import arm_bus_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [BE_W-1:0]   be,
    output logic              mismatch
);
    assign mismatch = |((a ^ b) & be_to_mask(be));
endmodule

// File: rtl/arm_bus_master.sv
// arm_bus_master: single-outstanding initiator for the ARM-style chip-select/strobe bus.
//   Parameters: STROBE_CYCLES (1..15) strobe low time, READ_LAT (1..15) strobe release to capture.
//   Ports: clk, rst_n (async, active-low), bif (arm_bus_master_if.master: cmd_*, rsp_*, bus_*).
//   Optional feature macro: ARM_BUS_MASTER_VERIFY_EN -- every write is read back and
//   compared on the enabled bytes; rsp_err flags a mismatch. Without it rsp_err is 0.
//   All outputs are registered: next-state values are decoded from the next FSM state.
module arm_bus_master
    import arm_bus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 32'd2,
    parameter int unsigned READ_LAT      = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    arm_bus_master_if.master bif
);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 32'd1);
    localparam logic [3:0] LAT_LOAD    = 4'(READ_LAT - 32'd1);

    state_e            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              wr_r;
    logic              accept_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              rsp_err_r, rsp_err_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
    logic              bus_as_r, bus_as_s;
    logic              bus_rs_n_r, bus_rs_n_s;
    logic              bus_ws_n_r, bus_ws_n_s;
    logic [ADDR_W-1:0] bus_address_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [BE_W-1:0]   bus_be_r;

    assign accept_s = bif.cmd_valid & cmd_ready_r;

`ifdef ARM_BUS_MASTER_VERIFY_EN
    logic mismatch_s;

    // The written word and byte enables are still held on the bus outputs during readback.
    arm_bus_be_cmp u_be_cmp (
        .a        (bif.bus_rdata),
        .b        (bus_wdata_r),
        .be       (bus_be_r),
        .mismatch (mismatch_s)
    );
`endif

    // Next-state and strobe/latency down-counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_SETUP;
                else          state_s = ST_IDLE;
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
                cnt_s   = STROBE_LOAD;
            end
            ST_STROBE: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else if (!wr_r) begin
                    state_s = ST_WAIT;
                    cnt_s   = LAT_LOAD;
                end else begin
`ifdef ARM_BUS_MASTER_VERIFY_EN
                    state_s = ST_VSETUP;
`else
                    state_s = ST_RESP;
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_r != 4'd0) cnt_s   = cnt_r - 4'd1;
                else               state_s = ST_RESP;
            end
            ST_RESP: begin
                if (bif.rsp_ready) state_s = ST_IDLE;
                else               state_s = ST_RESP;
            end
`ifdef ARM_BUS_MASTER_VERIFY_EN
            ST_VSETUP: begin
                state_s = ST_VSTROBE;
                cnt_s   = STROBE_LOAD;
            end
            ST_VSTROBE: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    state_s = ST_VWAIT;
                    cnt_s   = LAT_LOAD;
                end
            end
            ST_VWAIT: begin
                if (cnt_r != 4'd0) cnt_s   = cnt_r - 4'd1;
                else               state_s = ST_RESP;
            end
`endif
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Output values for the cycle after the coming edge, decoded from the next state.
    always_comb begin
        bus_as_s    = AS_IDLE;
        bus_rs_n_s  = STROBE_IDLE_N;
        bus_ws_n_s  = STROBE_IDLE_N;
        cmd_ready_s = (state_s == ST_IDLE);
        rsp_valid_s = (state_s == ST_RESP);
        case (state_s)
            ST_SETUP, ST_WAIT: begin
                bus_as_s = 1'b1;
            end
            ST_STROBE: begin
                bus_as_s = 1'b1;
                if (wr_r) bus_ws_n_s = 1'b0;
                else      bus_rs_n_s = 1'b0;
            end
`ifdef ARM_BUS_MASTER_VERIFY_EN
            ST_VSETUP, ST_VWAIT: begin
                bus_as_s = 1'b1;
            end
            ST_VSTROBE: begin
                bus_as_s   = 1'b1;
                bus_rs_n_s = 1'b0;
            end
`endif
            default: begin
                bus_as_s = AS_IDLE;
            end
        endcase
    end

    // Response data/error: capture on the edge that ends the last (V)WAIT cycle.
    always_comb begin
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        if ((state_r == ST_WAIT) && (state_s == ST_RESP)) begin
            rsp_rdata_s = bif.bus_rdata;
        end else if ((state_r == ST_STROBE) && (state_s == ST_RESP)) begin
            rsp_rdata_s = {DATA_W{1'b0}};
`ifdef ARM_BUS_MASTER_VERIFY_EN
        end else if ((state_r == ST_VWAIT) && (state_s == ST_RESP)) begin
            rsp_rdata_s = bif.bus_rdata;
            rsp_err_s   = mismatch_s;
`endif
        end else begin
            rsp_rdata_s = rsp_rdata_r;
        end
`ifdef ARM_BUS_MASTER_VERIFY_EN
        if (accept_s) rsp_err_s = 1'b0;
        else          rsp_err_s = rsp_err_s;
`else
        rsp_err_s = 1'b0;
`endif
    end

    // State, counter, command latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            wr_r          <= 1'b0;
            cmd_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            bus_as_r      <= AS_IDLE;
            bus_rs_n_r    <= STROBE_IDLE_N;
            bus_ws_n_r    <= STROBE_IDLE_N;
            bus_address_r <= {ADDR_W{1'b0}};
            bus_wdata_r   <= {DATA_W{1'b0}};
            bus_be_r      <= {BE_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cmd_ready_r <= cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
            bus_as_r    <= bus_as_s;
            bus_rs_n_r  <= bus_rs_n_s;
            bus_ws_n_r  <= bus_ws_n_s;
            if (accept_s) begin
                wr_r          <= bif.cmd_write;
                bus_address_r <= bif.cmd_addr;
                bus_wdata_r   <= bif.cmd_wdata;
                bus_be_r      <= bif.cmd_be;
            end
        end
    end

    assign bif.cmd_ready   = cmd_ready_r;
    assign bif.rsp_valid   = rsp_valid_r;
    assign bif.rsp_err     = rsp_err_r;
    assign bif.rsp_rdata   = rsp_rdata_r;
    assign bif.bus_as      = bus_as_r;
    assign bif.bus_rs_n    = bus_rs_n_r;
    assign bif.bus_ws_n    = bus_ws_n_r;
    assign bif.bus_address = bus_address_r;
    assign bif.bus_wdata   = bus_wdata_r;
    assign bif.bus_be      = bus_be_r;

endmodule

// File: tb/tb_arm_bus_master.sv
// tb_arm_bus_master: directed bench for arm_bus_master.
//   dut0 uses default timing (S=2, L=1) against a 16-word slave model;
//   dut1 uses S=1, L=3 with a fixed-value slave for back-pressure.
//   Cycle n = the clock period after the (n-1)th edge following the acceptance edge.
module tb_arm_bus_master;
    import arm_bus_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   viol  = 0;

    logic        ovr_en  = 1'b0;
    logic [31:0] ovr_val = 32'h0;
    logic [31:0] mem0   [16];
    logic [31:0] shadow [16];

    arm_bus_master_if bif0 ();
    arm_bus_master_if bif1 ();

    arm_bus_master dut0 (.clk(clk), .rst_n(rst_n), .bif(bif0));
    arm_bus_master #(.STROBE_CYCLES(1), .READ_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bif(bif1));

    always #5 clk = ~clk;

    // Slave model for dut0: byte-enabled writes on ws_n low, resets to the slave reset value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem0[i] <= SLAVE_RESET_VAL;
        end else if (!bif0.bus_ws_n) begin
            for (int b = 0; b < 4; b++)
                if (bif0.bus_be[b]) mem0[bif0.bus_address[3:0]][b*8 +: 8] <= bif0.bus_wdata[b*8 +: 8];
        end
    end
    assign bif0.bus_rdata = ovr_en ? ovr_val : mem0[bif0.bus_address[3:0]];
    assign bif1.bus_rdata = 32'h5A5A_0F0F;

    // Strobe-rule monitor on both masters.
    always @(negedge clk) begin
        if (!bif0.bus_rs_n && !bif0.bus_ws_n) viol++;
        if ((!bif0.bus_rs_n || !bif0.bus_ws_n) && !bif0.bus_as) viol++;
        if (!bif1.bus_rs_n && !bif1.bus_ws_n) viol++;
        if ((!bif1.bus_rs_n || !bif1.bus_ws_n) && !bif1.bus_as) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command on dut0 and trace cycles 1..first rsp_valid (rsp_ready held high).
    task automatic do_cmd0(input logic wr, input logic [23:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output logic [19:0] as_m, output logic [19:0] rs_m,
                           output logic [19:0] ws_m, output logic [31:0] rd, output logic er,
                           output int first, output logic [23:0] a1, output logic [3:0] be1);
        as_m = 20'h0; rs_m = 20'h0; ws_m = 20'h0; rd = 32'h0; er = 1'b0; first = -1;
        a1 = 24'h0; be1 = 4'h0;
        @(negedge clk);
        bif0.cmd_valid = 1'b1; bif0.cmd_write = wr; bif0.cmd_addr = addr;
        bif0.cmd_wdata = wd; bif0.cmd_be = be;
        @(posedge clk); #1 bif0.cmd_valid = 1'b0;
        for (int n = 1; n < 20 && first < 0; n++) begin
            @(negedge clk);
            as_m[n] = bif0.bus_as; rs_m[n] = ~bif0.bus_rs_n; ws_m[n] = ~bif0.bus_ws_n;
            if (n == 1) begin a1 = bif0.bus_address; be1 = bif0.bus_be; end
            if (bif0.rsp_valid) begin first = n; rd = bif0.rsp_rdata; er = bif0.rsp_err; end
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) shadow[addr[3:0]][b*8 +: 8] = wd[b*8 +: 8];
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bif0.cmd_ready !== 1'b1) begin n_mis++; $display("FAIL reset_cmd_ready: got %b want 1", bif0.cmd_ready); end
        n_cmp++; if (bif0.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid: got %b want 0", bif0.rsp_valid); end
        n_cmp++; if (bif0.rsp_rdata !== 32'h0) begin n_mis++; $display("FAIL reset_rsp_rdata: got %h want 0", bif0.rsp_rdata); end
        n_cmp++; if (bif0.rsp_err !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_err: got %b want 0", bif0.rsp_err); end
        n_cmp++; if ({bif0.bus_as, bif0.bus_rs_n, bif0.bus_ws_n} !== 3'b011) begin n_mis++; $display("FAIL reset_strobes: got %b want 011", {bif0.bus_as, bif0.bus_rs_n, bif0.bus_ws_n}); end
        n_cmp++; if ({bif0.bus_address, bif0.bus_wdata, bif0.bus_be} !== 60'h0) begin n_mis++; $display("FAIL reset_bus_regs: got %h want 0", {bif0.bus_address, bif0.bus_wdata, bif0.bus_be}); end
        n_cmp++; if (bif1.cmd_ready !== 1'b1) begin n_mis++; $display("FAIL reset_cmd_ready1: got %b want 1", bif1.cmd_ready); end
    endtask

    task automatic test_read();
        logic [19:0] as_m, rs_m, ws_m; logic [31:0] rd; logic er; int first; logic [23:0] a1; logic [3:0] be1;
        ovr_en = 1'b1; ovr_val = 32'h1234_5678;
        do_cmd0(1'b0, 24'h000000, 32'h0, 4'hF, as_m, rs_m, ws_m, rd, er, first, a1, be1);
        n_cmp++; if (first !== 5) begin n_mis++; $display("FAIL read_latency: got %0d want 5", first); end
        n_cmp++; if (rs_m !== 20'h0000C) begin n_mis++; $display("FAIL read_rs_cycles: got %h want 0000c", rs_m); end
        n_cmp++; if (ws_m !== 20'h0) begin n_mis++; $display("FAIL read_ws_cycles: got %h want 0", ws_m); end
        n_cmp++; if (as_m !== 20'h0001E) begin n_mis++; $display("FAIL read_as_cycles: got %h want 0001e", as_m); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_mis++; $display("FAIL read_data: got %h want 12345678", rd); end
        n_cmp++; if (be1 !== 4'hF) begin n_mis++; $display("FAIL read_be: got %h want f", be1); end
        ovr_en = 1'b0;
    endtask

    task automatic test_write_read();
        logic [19:0] as_m, rs_m, ws_m; logic [31:0] rd; logic er; int first; logic [23:0] a1; logic [3:0] be1;
        do_cmd0(1'b1, 24'h000000, 32'hCAFE_F00D, 4'hF, as_m, rs_m, ws_m, rd, er, first, a1, be1);
        n_cmp++; if (ws_m !== 20'h0000C) begin n_mis++; $display("FAIL write_ws_cycles: got %h want 0000c", ws_m); end
        n_cmp++; if (a1 !== 24'h0 || be1 !== 4'hF) begin n_mis++; $display("FAIL write_setup_bus: got %h/%h want 0/f", a1, be1); end
        n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL write_err: got %b want 0", er); end
`ifdef ARM_BUS_MASTER_VERIFY_EN
        n_cmp++; if (first !== 8) begin n_mis++; $display("FAIL write_latency: got %0d want 8", first); end
        n_cmp++; if (rs_m !== 20'h00060) begin n_mis++; $display("FAIL write_rs_cycles: got %h want 00060", rs_m); end
        n_cmp++; if (as_m !== 20'h000FE) begin n_mis++; $display("FAIL write_as_cycles: got %h want 000fe", as_m); end
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_mis++; $display("FAIL write_rdata: got %h want cafef00d", rd); end
`else
        n_cmp++; if (first !== 4) begin n_mis++; $display("FAIL write_latency: got %0d want 4", first); end
        n_cmp++; if (rs_m !== 20'h0) begin n_mis++; $display("FAIL write_rs_cycles: got %h want 0", rs_m); end
        n_cmp++; if (as_m !== 20'h0000E) begin n_mis++; $display("FAIL write_as_cycles: got %h want 0000e", as_m); end
        n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL write_rdata: got %h want 0", rd); end
`endif
        do_cmd0(1'b0, 24'h000000, 32'h0, 4'hF, as_m, rs_m, ws_m, rd, er, first, a1, be1);
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_mis++; $display("FAIL readback: got %h want cafef00d", rd); end
        n_cmp++; if (first !== 5) begin n_mis++; $display("FAIL readback_latency: got %0d want 5", first); end
    endtask

    task automatic test_back_pressure();
        int first = -1;
        bool_seen: begin end
        @(negedge clk);
        bif1.cmd_valid = 1'b1; bif1.cmd_write = 1'b0; bif1.cmd_addr = 24'h000010;
        bif1.cmd_wdata = 32'h0; bif1.cmd_be = 4'hF; bif1.rsp_ready = 1'b0;
        @(posedge clk); #1 bif1.cmd_valid = 1'b0;
        for (int n = 1; n < 16 && first < 0; n++) begin
            @(negedge clk);
            if (bif1.rsp_valid) first = n;
        end
        n_cmp++; if (first !== 6) begin n_mis++; $display("FAIL bp_latency: got %0d want 6", first); end
        bif1.cmd_valid = 1'b1; bif1.cmd_write = 1'b1; bif1.cmd_addr = 24'h000020;
        bif1.cmd_wdata = 32'h0102_0304;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bif1.rsp_valid !== 1'b1) begin n_mis++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", k, bif1.rsp_valid); end
            n_cmp++; if (bif1.rsp_rdata !== 32'h5A5A_0F0F) begin n_mis++; $display("FAIL bp_rsp_rdata[%0d]: got %h want 5a5a0f0f", k, bif1.rsp_rdata); end
            n_cmp++; if (bif1.cmd_ready !== 1'b0) begin n_mis++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", k, bif1.cmd_ready); end
            n_cmp++; if (bif1.bus_as !== 1'b0) begin n_mis++; $display("FAIL bp_bus_as[%0d]: got %b want 0", k, bif1.bus_as); end
            @(negedge clk);
        end
        bif1.rsp_ready = 1'b1;
        n_cmp++; if (bif1.rsp_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid_at_hs: got %b want 1", bif1.rsp_valid); end
        @(negedge clk);
        n_cmp++; if ({bif1.cmd_ready, bif1.rsp_valid} !== 2'b10) begin n_mis++; $display("FAIL bp_idle_after_hs: got %b want 10", {bif1.cmd_ready, bif1.rsp_valid}); end
        @(negedge clk);
        bif1.cmd_valid = 1'b0;
        n_cmp++; if ({bif1.cmd_ready, bif1.bus_as} !== 2'b01) begin n_mis++; $display("FAIL bp_next_accept: got %b want 01", {bif1.cmd_ready, bif1.bus_as}); end
        n_cmp++; if (bif1.bus_address !== 24'h000020) begin n_mis++; $display("FAIL bp_next_addr: got %h want 000020", bif1.bus_address); end
        first = -1;
        for (int n = 2; n < 20 && first < 0; n++) begin
            @(negedge clk);
            if (bif1.rsp_valid) first = n;
        end
        n_cmp++; if (first < 0) begin n_mis++; $display("FAIL bp_next_rsp: got timeout want response"); end
        @(posedge clk); #1;
    endtask

`ifdef ARM_BUS_MASTER_VERIFY_EN
    task automatic test_verify();
        logic [19:0] as_m, rs_m, ws_m; logic [31:0] rd; logic er; int first; logic [23:0] a1; logic [3:0] be1;
        ovr_en = 1'b1; ovr_val = 32'h0000_CCDD;
        do_cmd0(1'b1, 24'h000004, 32'hAABB_CCDD, 4'h3, as_m, rs_m, ws_m, rd, er, first, a1, be1);
        n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL verify_match_err: got %b want 0", er); end
        n_cmp++; if (rd !== 32'h0000_CCDD) begin n_mis++; $display("FAIL verify_match_rdata: got %h want 0000ccdd", rd); end
        ovr_val = 32'h0000_CC00;
        do_cmd0(1'b1, 24'h000004, 32'hAABB_CCDD, 4'h3, as_m, rs_m, ws_m, rd, er, first, a1, be1);
        n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL verify_mismatch_err: got %b want 1", er); end
        n_cmp++; if (rd !== 32'h0000_CC00) begin n_mis++; $display("FAIL verify_mismatch_rdata: got %h want 0000cc00", rd); end
        do_cmd0(1'b1, 24'h000004, 32'hAABB_CCDD, 4'h0, as_m, rs_m, ws_m, rd, er, first, a1, be1);
        n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL verify_be0_err: got %b want 0", er); end
        ovr_en = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_strobe();
        int seen = 0;
        @(negedge clk);
        bif0.cmd_valid = 1'b1; bif0.cmd_write = 1'b0; bif0.cmd_addr = 24'h000008; bif0.cmd_be = 4'hF;
        @(posedge clk); #1 bif0.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bif0.bus_rs_n !== 1'b0) begin n_mis++; $display("FAIL mid_in_strobe: got %b want 0", bif0.bus_rs_n); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bif0.bus_as, bif0.bus_rs_n, bif0.rsp_valid, bif0.cmd_ready} !== 4'b0101) begin n_mis++; $display("FAIL mid_reset_outputs: got %b want 0101", {bif0.bus_as, bif0.bus_rs_n, bif0.rsp_valid, bif0.cmd_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = SLAVE_RESET_VAL;
        repeat (8) begin
            @(negedge clk);
            if (bif0.rsp_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL mid_no_response: got %0d responses want 0", seen); end
    endtask

    task automatic test_strobe_exclusivity();
        logic [19:0] as_m, rs_m, ws_m; logic [31:0] rd, exp; logic er; int first; logic [23:0] a1; logic [3:0] be1;
        logic wr; logic [23:0] addr; logic [31:0] wd; logic [3:0] be;
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            wr = 1'($urandom_range(0, 1)); addr = 24'($urandom); wd = $urandom; be = 4'($urandom);
            do_cmd0(wr, addr, wd, be, as_m, rs_m, ws_m, rd, er, first, a1, be1);
`ifdef ARM_BUS_MASTER_VERIFY_EN
            exp = shadow[addr[3:0]];
`else
            exp = wr ? 32'h0 : shadow[addr[3:0]];
`endif
            n_cmp++; if (first < 0) begin n_mis++; $display("FAIL rand_rsp[%0d]: got timeout want response", i); end
            n_cmp++; if (rd !== exp || er !== 1'b0) begin n_mis++; $display("FAIL rand_data[%0d]: got %h/%b want %h/0", i, rd, er, exp); end
        end
        n_cmp++; if (viol !== 0) begin n_mis++; $display("FAIL strobe_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        bif0.cmd_valid = 1'b0; bif0.cmd_write = 1'b0; bif0.cmd_addr = 24'h0;
        bif0.cmd_wdata = 32'h0; bif0.cmd_be = 4'h0; bif0.rsp_ready = 1'b1;
        bif1.cmd_valid = 1'b0; bif1.cmd_write = 1'b0; bif1.cmd_addr = 24'h0;
        bif1.cmd_wdata = 32'h0; bif1.cmd_be = 4'h0; bif1.rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = SLAVE_RESET_VAL;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_read();
        test_write_read();
        test_back_pressure();
`ifdef ARM_BUS_MASTER_VERIFY_EN
        test_verify();
`endif
        test_reset_mid_strobe();
        test_strobe_exclusivity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
